// File: rtl/priority_encoder_8x3_if.sv
// Request/code bus of the 8-to-3 priority encoder: requests and ack in,
// registered code, valid and debug state out.
interface priority_encoder_8x3_if #(
  parameter int MISS_W = 4
);
  logic              En;
  logic [7:0]        D;
  logic              ack;
  logic              A;
  logic              B;
  logic              C;
  logic              V;
  logic [7:0]        pending;
  logic [MISS_W-1:0] miss;

  modport master (output En, D, ack, input A, B, C, V, pending, miss);
  modport slave  (input En, D, ack, output A, B, C, V, pending, miss);
endinterface

// File: rtl/priority_encoder_8x3.sv
// Sequential 8-to-3 priority encoder: latches request rising edges into a pending
// set and presents the highest pending index, held until acknowledged.
module priority_encoder_8x3 #(
  parameter int MISS_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  priority_encoder_8x3_if.slave  bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  function automatic logic [MISS_W-1:0] f_sat_inc(input logic [MISS_W-1:0] v);
    return (v == MISS_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [2:0] f_top_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  state_t            r_state;
  logic [7:0]        r_d_q;
  logic [7:0]        r_pending;
  logic [MISS_W-1:0] r_miss;
  logic [2:0]        r_code;
  logic              r_v;

  logic [7:0] w_set;
  logic [7:0] w_clr;
  logic [7:0] w_kept;
  logic [7:0] w_pnext;
  logic       w_collide;

  // A clear and a set on the same bit leave it pending: the set is ORed in after the clear.
  assign w_set     = bus.En ? (bus.D & ~r_d_q) : 8'd0;
  assign w_clr     = (r_v && bus.ack) ? (8'd1 << r_code) : 8'd0;
  assign w_kept    = r_pending & ~w_clr;
  assign w_pnext   = w_kept | w_set;
  assign w_collide = |(w_set & w_kept);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_d_q     <= 8'd0;
      r_pending <= 8'd0;
      r_miss    <= '0;
      r_code    <= 3'd0;
      r_v       <= 1'b0;
    end else begin
      r_d_q     <= bus.D;
      r_pending <= w_pnext;
      if (w_collide) r_miss <= f_sat_inc(r_miss);
      case (r_state)
        IDLE: begin
          if (w_pnext != 8'd0) begin
            r_code  <= f_top_idx(w_pnext);
            r_v     <= 1'b1;
            r_state <= PRESENT;
          end else begin
            r_code <= 3'd0;
            r_v    <= 1'b0;
          end
        end
        PRESENT: begin
          // Without ack the code is frozen; higher-priority arrivals wait in pending.
          if (bus.ack) begin
            if (w_pnext != 8'd0) begin
              r_code <= f_top_idx(w_pnext);
            end else begin
              r_code  <= 3'd0;
              r_v     <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_v     <= 1'b0;
          r_code  <= 3'd0;
        end
      endcase
    end
  end

  assign bus.A       = r_code[2];
  assign bus.B       = r_code[1];
  assign bus.C       = r_code[0];
  assign bus.V       = r_v;
  assign bus.pending = r_pending;
  assign bus.miss    = r_miss;

endmodule

// File: doc/priority_encoder_8x3.md
Name: priority_encoder_8x3

Overview:
Sequential 8-to-3 priority encoder: the inverse of the 3x8 decoder. It captures rising edges on eight one-hot request lines into a pending register and presents the highest-priority pending index as a 3-bit code with a valid flag. The code is held stable until acknowledged. Outputs A (MSB), B, C match the decoder's select inputs, so this block's code can drive the decoder directly to regenerate the one-hot line.

Parameters:
MISS_W, 4, width of saturating missed-request counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
En  input  1  capture enable for new requests
D  input  8  request lines; D[7] highest priority, D[0] lowest
ack  input  1  consumer accepts presented code
A  output  1  code bit 2 (MSB), registered
B  output  1  code bit 1, registered
C  output  1  code bit 0, registered
V  output  1  code valid, registered
pending  output  8  pending request register, for debug/verification
miss  output  MISS_W  saturating count of rising edges lost on already-pending bits

Behaviour:
- Reset (rst=1 at an edge):
  - pending=0, d_q=0, V=0, {A,B,C}=0, miss=0, FSM=IDLE.
  - Reset dominates ack and captures in the same cycle.
- Edge detect:
  - d_q <= D every non-reset cycle, regardless of En.
  - rise = D & ~d_q.
  - Because d_q=0 after reset, a line held high through reset counts as one rise on the first post-reset edge.
- Capture: set_mask = En ? rise : 0. With En=0, rises are discarded, not deferred.
- Clear: clr_mask = one-hot of {A,B,C} when (V && ack), else 0. ack with V=0 is ignored.
- pending_next = (pending & ~clr_mask) | set_mask.
  - Set wins over clear on the same bit in the same cycle, so the bit stays pending.
- Miss counter:
  - Increments by 1 at an edge when any set_mask bit is already 1 in (pending & ~clr_mask).
  - Counts at most once per cycle, even if several bits collide.
  - Saturates at 2^MISS_W-1.
- FSM: two states, IDLE (V=0) and PRESENT (V=1).
  - IDLE:
    - If pending_next != 0: load {A,B,C} = index of highest set bit of pending_next, V<=1, go to PRESENT.
    - Otherwise stay in IDLE with {A,B,C}=0.
  - PRESENT, ack=0:
    - {A,B,C} and V are held.
    - A newly captured higher-priority request does NOT preempt; it waits in pending.
  - PRESENT, ack=1:
    - The presented bit is cleared.
    - If pending_next != 0: load the new highest index, stay in PRESENT (back-to-back acks allowed, one code per cycle).
    - Otherwise V<=0, {A,B,C}<=0, go to IDLE.
- Latency:
  - Request rising before edge k (with En=1) and pending previously empty: V=1 and code valid immediately after edge k.
  - Ack sampled at edge k: next code (or V=0) valid after edge k.
- Invariants:
  - V==1 implies pending[{A,B,C}]==1.
  - V==0 implies pending==0 after any edge.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with D=8'hFF → V=0, ABC=000, pending=0, miss=0. Release rst with D=8'hFF, En=1 → after 1st edge pending=FF, V=1, ABC=111.
- Single request: En=1, pulse D=8'h08 for 1 cycle → V=1, ABC=011 after that edge. Hold ack=1 one cycle → pending=00, V=0.
- Priority and no preemption: pulse D=8'h05 → ABC=010. Then pulse D=8'h40 while ack=0 → ABC stays 010, pending=45. Three back-to-back acks → codes 010, 110, 000 in that order, then V=0.
- Enable gating: En=0, pulse D=8'h80 → pending stays 00, V=0. Raise En while D held high → no capture; drop D, then pulse D=8'h80 → ABC=111.
- Collision, set-wins, and miss counter: present bit 3 (ABC=011). Pulse D=8'h08 with ack=1 in the same cycle → pending[3] stays 1, V=1, ABC=011, miss unchanged. Pulse D=8'h08 again with ack=0 → miss=1. Repeat 20 times → miss saturates at 15.
- Loopback: drive the decoder with this block's {A,B,C} and En=V. For each single-bit D pulse 8'h01..8'h80 → decoder output equals that pulse's one-hot pattern.
